// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SRAM responder: FSM states, the
// out-of-range read value, the latency LFSR polynomial and a byte-merge helper.
package sram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Data returned with resp_err for an unmapped address.
    localparam logic [31:0] ERR_RDATA = 32'h0;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Word after a byte-enabled write: lane i comes from new_word when mask[i] is set.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  mask
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_lat_lfsr.sv
// 16-bit Galois LFSR used as the random response-latency source.
// Advances one step per cycle while en is high; reloads SEED on reset.
module sram_lat_lfsr
    import sram_resp_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next LFSR value: shift right and fold the feedback mask in when bit 0 was set.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {1'b0, lfsr_q[15:1]};
            if (lfsr_q[0]) begin
                lfsr_d = lfsr_d ^ LFSR_TAPS;
            end
        end
    end

    // LFSR state register with synchronous reload of the seed.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/sram_resp_slave.sv
// Word-addressed behavioural SRAM responder with a valid/ready request and
// response handshake and fixed or LFSR-random response latency.
module sram_resp_slave
    import sram_resp_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter logic [31:0] BASE     = 32'h8000_0000,
    parameter bit          RAND_LAT = 1'b0,
    parameter int unsigned FIX_LAT  = 1,
    parameter int unsigned MAX_LAT  = 7,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sram_addr,
    input  logic        arvalid,
    output logic        arready,
    input  logic        sram_wen,
    input  logic [3:0]  sram_wmask,
    input  logic [31:0] sram_wdata,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] sram_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 8;
    // One past the last mapped byte, widened so BASE + 4*DEPTH cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'(DEPTH) << 2);

    logic [31:0] mem_q [DEPTH];

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic               in_range_q, in_range_d;
    logic [31:0]        rdata_q,    rdata_d;
    logic               err_q,      err_d;
    logic               rvalid_q,   rvalid_d;

    logic               hs;
    logic               hs_in_range;
    logic [IDX_W-1:0]   hs_idx;
    logic [15:0]        lfsr_val;
    logic [CNT_W-1:0]   lat_sel;

    assign arready     = (state_q == IDLE) && !rst;
    assign hs          = arvalid && arready;
    assign hs_in_range = ({1'b0, sram_addr} >= {1'b0, BASE}) && ({1'b0, sram_addr} < LIMIT);
    assign hs_idx      = IDX_W'((sram_addr - BASE) >> 2);
    assign lat_sel     = RAND_LAT ? CNT_W'(lfsr_val & 16'(MAX_LAT)) : CNT_W'(FIX_LAT);

    sram_lat_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (hs),
        .lfsr (lfsr_val)
    );

    // Byte-enabled write at the address handshake; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; contents survive rst like a real SRAM.
        if (hs && sram_wen && hs_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_wmask[i]) begin
                    mem_q[hs_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Next-state and response datapath; rdata is captured on the edge entering RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        in_range_d = in_range_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        rvalid_d   = rvalid_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    idx_d      = hs_idx;
                    in_range_d = hs_in_range;
                    cnt_d      = lat_sel;
                    if (lat_sel != '0) begin
                        state_d = WAIT;
                    end else begin
                        // Zero latency: the write lands on this same edge, so forward the merged word.
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        err_d    = !hs_in_range;
                        if (!hs_in_range) begin
                            rdata_d = ERR_RDATA;
                        end else if (sram_wen) begin
                            rdata_d = byte_merge(mem_q[hs_idx], sram_wdata, sram_wmask);
                        end else begin
                            rdata_d = mem_q[hs_idx];
                        end
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    err_d    = !in_range_q;
                    rdata_d  = in_range_q ? mem_q[idx_q] : ERR_RDATA;
                end
            end
            RESP: begin
                if (rready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                rvalid_d = 1'b0;
            end
        endcase
    end

    // FSM state, latency counter, transaction context and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign rvalid     = rvalid_q;
    assign sram_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_sram_resp_slave.sv
// Directed bench for sram_resp_slave. Three instances share one clock:
// u0 fixed latency 0, u1 fixed latency 3, u2 LFSR-random latency 0..7.
module tb_sram_resp_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 64;
    localparam logic [31:0] OOR   = BASE + 32'(4 * DEPTH);

    logic        clk = 1'b0;
    logic        rst        [3];
    logic [31:0] addr       [3];
    logic        arvalid    [3];
    logic        arready    [3];
    logic        wen        [3];
    logic [3:0]  wmask      [3];
    logic [31:0] wdata      [3];
    logic        rvalid     [3];
    logic        rready     [3];
    logic [31:0] rdata      [3];
    logic        resp_err   [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_resp_slave #(.DEPTH(DEPTH), .BASE(BASE), .RAND_LAT(1'b0), .FIX_LAT(0)) u0 (
        .clk(clk), .rst(rst[0]), .sram_addr(addr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
        .sram_wen(wen[0]), .sram_wmask(wmask[0]), .sram_wdata(wdata[0]), .rvalid(rvalid[0]),
        .rready(rready[0]), .sram_rdata(rdata[0]), .resp_err(resp_err[0]));

    sram_resp_slave #(.DEPTH(DEPTH), .BASE(BASE), .RAND_LAT(1'b0), .FIX_LAT(3)) u1 (
        .clk(clk), .rst(rst[1]), .sram_addr(addr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
        .sram_wen(wen[1]), .sram_wmask(wmask[1]), .sram_wdata(wdata[1]), .rvalid(rvalid[1]),
        .rready(rready[1]), .sram_rdata(rdata[1]), .resp_err(resp_err[1]));

    sram_resp_slave #(.DEPTH(DEPTH), .BASE(BASE), .RAND_LAT(1'b1), .MAX_LAT(7), .SEED(16'hACE1)) u2 (
        .clk(clk), .rst(rst[2]), .sram_addr(addr[2]), .arvalid(arvalid[2]), .arready(arready[2]),
        .sram_wen(wen[2]), .sram_wmask(wmask[2]), .sram_wdata(wdata[2]), .rvalid(rvalid[2]),
        .rready(rready[2]), .sram_rdata(rdata[2]), .resp_err(resp_err[2]));

    // Reference byte merge for the scoreboard.
    function automatic logic [31:0] merge_ref(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // One full transaction; lat = negedges from the handshake sample to the first rvalid sample.
    task automatic run_txn(input int u, input logic [31:0] a, input logic w, input logic [3:0] m,
                           input logic [31:0] d, output logic [31:0] rd, output logic er,
                           output int lat, output bit ok);
        int guard;
        ok = 1'b1; rd = '0; er = 1'b0; lat = 0; guard = 0;
        @(negedge clk);
        while (!arready[u] && guard < 50) begin @(negedge clk); guard++; end
        if (!arready[u]) begin ok = 1'b0; return; end
        addr[u] = a; wen[u] = w; wmask[u] = m; wdata[u] = d; arvalid[u] = 1'b1;
        @(negedge clk);
        arvalid[u] = 1'b0; wen[u] = 1'b0; lat = 1;
        while (!rvalid[u] && lat < 40) begin @(negedge clk); lat++; end
        if (!rvalid[u]) begin ok = 1'b0; return; end
        rd = rdata[u]; er = resp_err[u];
        rready[u] = 1'b1;
        @(negedge clk);
        rready[u] = 1'b0;
        if (rvalid[u] !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1; arvalid[u] = 1'b1; wen[u] = 1'b1; wmask[u] = 4'hF;
            addr[u] = BASE; wdata[u] = 32'hDEAD_BEEF;
        end
        repeat (3) begin
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                total++;
                if ({arready[u], rvalid[u]} !== 2'b00)
                    begin bad++; $display("FAIL reset_hold u%0d: arready,rvalid=%b%b want 00", u, arready[u], rvalid[u]); end
            end
        end
        for (int u = 0; u < 3; u++) begin
            total++;
            if ({resp_err[u], rdata[u]} !== 33'h0)
                begin bad++; $display("FAIL reset_outputs u%0d: err=%b rdata=%h want 0/00000000", u, resp_err[u], rdata[u]); end
            arvalid[u] = 1'b0; wen[u] = 1'b0; rst[u] = 1'b0;
        end
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            total++;
            if ({arready[u], rvalid[u]} !== 2'b10)
                begin bad++; $display("FAIL reset_release u%0d: arready,rvalid=%b%b want 10", u, arready[u], rvalid[u]); end
        end
    endtask

    task automatic test_fix0();
        logic [31:0] rd; logic er; int lat; bit ok;
        run_txn(0, BASE, 1'b1, 4'hF, 32'h1234_5678, rd, er, lat, ok);
        total++; if (!ok || lat != 1) begin bad++; $display("FAIL fix0_wr_lat: ok=%0d lat=%0d want 1/1", ok, lat); end
        total++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin bad++; $display("FAIL fix0_wr_ack: rdata=%h err=%b want 12345678/0", rd, er); end
        run_txn(0, BASE, 1'b0, 4'h0, 32'h0, rd, er, lat, ok);
        total++; if (!ok || lat != 1) begin bad++; $display("FAIL fix0_rd_lat: ok=%0d lat=%0d want 1/1", ok, lat); end
        total++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin bad++; $display("FAIL fix0_rd_data: rdata=%h err=%b want 12345678/0", rd, er); end
    endtask

    task automatic test_byte_mask();
        logic [31:0] rd; logic er; int lat; bit ok;
        run_txn(0, BASE + 4, 1'b1, 4'hF, 32'hFFFF_FFFF, rd, er, lat, ok);
        run_txn(0, BASE + 4, 1'b1, 4'b0010, 32'h0000_AB00, rd, er, lat, ok);
        total++; if (!ok || rd !== 32'hFFFF_ABFF) begin bad++; $display("FAIL mask_wr_ack: rdata=%h want ffffabff", rd); end
        run_txn(0, BASE + 4, 1'b0, 4'h0, 32'h0, rd, er, lat, ok);
        total++; if (!ok || rd !== 32'hFFFF_ABFF) begin bad++; $display("FAIL mask_rd: rdata=%h want ffffabff", rd); end
        run_txn(0, BASE + 4, 1'b1, 4'h0, 32'h0000_0000, rd, er, lat, ok);
        run_txn(0, BASE + 7, 1'b0, 4'h0, 32'h0, rd, er, lat, ok);
        total++; if (!ok || rd !== 32'hFFFF_ABFF || er !== 1'b0)
            begin bad++; $display("FAIL mask_zero_unaligned: rdata=%h err=%b want ffffabff/0", rd, er); end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic er; int lat; bit ok;
        run_txn(0, OOR, 1'b0, 4'h0, 32'h0, rd, er, lat, ok);
        total++; if (!ok || rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL range_rd_hi: rdata=%h err=%b want 00000000/1", rd, er); end
        run_txn(0, OOR, 1'b1, 4'hF, 32'h1111_1111, rd, er, lat, ok);
        total++; if (!ok || rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL range_wr_hi: rdata=%h err=%b want 00000000/1", rd, er); end
        run_txn(0, BASE - 4, 1'b0, 4'h0, 32'h0, rd, er, lat, ok);
        total++; if (!ok || rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL range_rd_lo: rdata=%h err=%b want 00000000/1", rd, er); end
        run_txn(0, BASE, 1'b0, 4'h0, 32'h0, rd, er, lat, ok);
        total++; if (!ok || rd !== 32'h1234_5678 || er !== 1'b0) begin bad++; $display("FAIL range_intact: rdata=%h err=%b want 12345678/0", rd, er); end
    endtask

    task automatic test_reset_blocks_write();
        logic [31:0] rd; logic er; int lat; bit ok;
        @(negedge clk);
        rst[0] = 1'b1; arvalid[0] = 1'b1; wen[0] = 1'b1; wmask[0] = 4'hF; addr[0] = BASE; wdata[0] = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            total++; if (arready[0] !== 1'b0) begin bad++; $display("FAIL rst_arready: arready=%b want 0", arready[0]); end
        end
        arvalid[0] = 1'b0; wen[0] = 1'b0; rst[0] = 1'b0;
        run_txn(0, BASE, 1'b0, 4'h0, 32'h0, rd, er, lat, ok);
        total++; if (!ok || rd !== 32'h1234_5678) begin bad++; $display("FAIL rst_no_write: rdata=%h want 12345678", rd); end
    endtask

    task automatic test_fix3_hold();
        logic [31:0] rd; logic er; int lat; bit ok;
        run_txn(1, BASE + 20, 1'b1, 4'hF, 32'h2020_2020, rd, er, lat, ok);
        run_txn(1, BASE + 16, 1'b1, 4'hF, 32'hA5A5_5A5A, rd, er, lat, ok);
        total++; if (!ok || lat != 4 || rd !== 32'hA5A5_5A5A)
            begin bad++; $display("FAIL fix3_wr: ok=%0d lat=%0d rdata=%h want 1/4/a5a55a5a", ok, lat, rd); end
        @(negedge clk);
        addr[1] = BASE + 16; wen[1] = 1'b0; arvalid[1] = 1'b1;
        @(negedge clk);
        arvalid[1] = 1'b0; lat = 1;
        while (!rvalid[1] && lat < 40) begin @(negedge clk); lat++; end
        total++; if (rvalid[1] !== 1'b1 || lat != 4) begin bad++; $display("FAIL fix3_rd_lat: rvalid=%b lat=%0d want 1/4", rvalid[1], lat); end
        addr[1] = BASE + 20; wen[1] = 1'b1; wmask[1] = 4'hF; wdata[1] = 32'h0; arvalid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({rvalid[1], arready[1]} !== 2'b10 || rdata[1] !== 32'hA5A5_5A5A)
                begin bad++; $display("FAIL fix3_hold c%0d: rvalid,arready=%b%b rdata=%h want 10/a5a55a5a", c, rvalid[1], arready[1], rdata[1]); end
        end
        arvalid[1] = 1'b0; wen[1] = 1'b0; rready[1] = 1'b1;
        @(negedge clk);
        rready[1] = 1'b0;
        total++; if ({rvalid[1], arready[1]} !== 2'b01) begin bad++; $display("FAIL fix3_retire: rvalid,arready=%b%b want 01", rvalid[1], arready[1]); end
        run_txn(1, BASE + 20, 1'b0, 4'h0, 32'h0, rd, er, lat, ok);
        total++; if (!ok || rd !== 32'h2020_2020) begin bad++; $display("FAIL fix3_ignored_req: rdata=%h want 20202020", rd); end
    endtask

    task automatic test_rst_mid_wait();
        logic [31:0] rd; logic er; int lat; bit ok; bit seen_rv;
        @(negedge clk);
        addr[1] = BASE + 12; wen[1] = 1'b1; wmask[1] = 4'hF; wdata[1] = 32'h5A5A_5A5A; arvalid[1] = 1'b1;
        @(negedge clk);
        arvalid[1] = 1'b0; wen[1] = 1'b0; rst[1] = 1'b1;
        @(negedge clk);
        total++; if ({rvalid[1], arready[1]} !== 2'b00) begin bad++; $display("FAIL midwait_rst: rvalid,arready=%b%b want 00", rvalid[1], arready[1]); end
        rst[1] = 1'b0;
        seen_rv = 1'b0;
        repeat (6) begin @(negedge clk); if (rvalid[1]) seen_rv = 1'b1; end
        total++; if (seen_rv || arready[1] !== 1'b1) begin bad++; $display("FAIL midwait_idle: rvalid_seen=%0d arready=%b want 0/1", seen_rv, arready[1]); end
        run_txn(1, BASE + 12, 1'b0, 4'h0, 32'h0, rd, er, lat, ok);
        total++; if (!ok || rd !== 32'h5A5A_5A5A) begin bad++; $display("FAIL midwait_write_kept: rdata=%h want 5a5a5a5a", rd); end
    endtask

    task automatic test_random();
        logic [31:0] model [DEPTH];
        bit          seen  [8];
        logic [31:0] rd, a, d, exp_d; logic er, w, exp_e; logic [3:0] m; int lat, idx; bit ok;
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        for (int n = 0; n < DEPTH + 1000; n++) begin
            idx = $urandom_range(0, DEPTH - 1);
            if (n < DEPTH) begin
                idx = n; w = 1'b1; m = 4'hF;
            end else begin
                w = 1'($urandom_range(0, 1)); m = 4'($urandom_range(0, 15));
            end
            d = $urandom;
            a = BASE + 32'(4 * idx) + 32'($urandom_range(0, 3));
            exp_e = 1'b0;
            if (n >= DEPTH && $urandom_range(0, 15) == 0) begin
                a = ($urandom_range(0, 1) == 0) ? OOR + 32'(4 * $urandom_range(0, 15)) : BASE - 32'(4 * $urandom_range(1, 4));
                exp_e = 1'b1;
            end
            if (exp_e) exp_d = 32'h0;
            else begin
                if (w) model[idx] = merge_ref(model[idx], d, m);
                exp_d = model[idx];
            end
            run_txn(2, a, w, m, d, rd, er, lat, ok);
            total++;
            if (!ok || lat < 1 || lat > 8)
                begin bad++; $display("FAIL rand_lat n%0d: ok=%0d latency=%0d want 0..7", n, ok, lat - 1); end
            else seen[lat - 1] = 1'b1;
            total++;
            if (rd !== exp_d || er !== exp_e)
                begin bad++; $display("FAIL rand_data n%0d addr=%h: rdata=%h err=%b want %h/%b", n, a, rd, er, exp_d, exp_e); end
        end
        for (int v = 0; v < 8; v++) begin
            total++; if (!seen[v]) begin bad++; $display("FAIL rand_lat_cover: latency %0d seen=0 want 1", v); end
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1; addr[u] = '0; arvalid[u] = 1'b0; wen[u] = 1'b0;
            wmask[u] = '0; wdata[u] = '0; rready[u] = 1'b0;
        end
        test_reset();
        test_fix0();
        test_byte_mask();
        test_range();
        test_reset_blocks_write();
        test_fix3_hold();
        test_rst_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
